ray_scheduler: RTL and testbench

- Frame-level sequencer for the ray-tracing datapath.
- On each frame_clk rising edge it walks every pixel in raster order and issues one ray request per pixel to the intersection pipeline over a valid/ready handshake.
- Pixel coordinates are held in an in-order FIFO so that each returning result (object index, tbest) is re-tagged with its pixel.
- Tagged results drive WritePixel/WriteX/WriteY/best/tbest for the framebuffer writer and hit_detection.

---
 rtl/rt_pkg.sv | 27 ++
 rtl/coord_fifo.sv | 51 +++++
 rtl/ray_scheduler.sv | 115 +++++++++++
 tb/tb_ray_scheduler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rt_pkg.sv
// rtl/rt_pkg.sv - shared ray-tracing types and frame constants
package rt_pkg;

    localparam int          H_RES  = 640;
    localparam int          V_RES  = 480;
    localparam logic [63:0] T_MISS = 64'hEFFF_FFFF_FFFF_FFFF;

    typedef logic signed [63:0] fixed_real;

    typedef struct packed {
        fixed_real x;
        fixed_real y;
        fixed_real z;
    } vector;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } pix_coord_t;

endpackage

// File: rtl/coord_fifo.sv
// rtl/coord_fifo.sv - in-order pixel coordinate FIFO for rays in flight
module coord_fifo
    import rt_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       push,
    input  logic       pop,
    input  pix_coord_t din,
    output pix_coord_t dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    pix_coord_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            wr_en;
    logic            rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !rd_en)      count <= count + (AW+1)'(1);
            else if (!wr_en && rd_en) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ray_scheduler.sv
// rtl/ray_scheduler.sv - frame sequencer issuing one ray per pixel and re-tagging results
module ray_scheduler #(
    parameter int H_RES           = rt_pkg::H_RES,
    parameter int V_RES           = rt_pkg::V_RES,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [9:0]  req_x,
    output logic [9:0]  req_y,
    input  logic        res_valid,
    input  logic [1:0]  res_index,
    input  logic [63:0] res_t,
    output logic        WritePixel,
    output logic [9:0]  WriteX,
    output logic [9:0]  WriteY,
    output logic [1:0]  best_out,
    output logic [63:0] tbest_out,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun,
    output logic        stray_err
);

    import rt_pkg::pix_coord_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

    state_t     state, state_next;
    logic       old_frame_clk;
    logic       frame_rise;
    logic [9:0] x_cnt, y_cnt;
    logic       fifo_full, fifo_empty;
    logic       push, pop, last_pixel;
    pix_coord_t fifo_din, fifo_dout;

    assign fifo_din = '{x: x_cnt, y: y_cnt};
    assign req_x    = x_cnt;
    assign req_y    = y_cnt;
    assign busy     = (state != IDLE);

    coord_fifo #(.DEPTH(MAX_OUTSTANDING)) u_coord_fifo (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .push    (push),
        .pop     (pop),
        .din     (fifo_din),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        frame_rise = frame_clk & ~old_frame_clk;
        req_valid  = (state == ISSUE) && !fifo_full;
        push       = req_valid && req_ready;
        pop        = res_valid && !fifo_empty;
        last_pixel = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
        // The last pop empties the FIFO; its write-back lands in the same cycle as this.
        frame_done = (state == DRAIN) && fifo_empty;
        state_next = state;
        case (state)
            IDLE:    if (frame_rise)         state_next = ISSUE;
            ISSUE:   if (push && last_pixel) state_next = DRAIN;
            DRAIN:   if (fifo_empty)         state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state         <= IDLE;
            old_frame_clk <= 1'b0;
            x_cnt         <= '0;
            y_cnt         <= '0;
            WritePixel    <= 1'b0;
            WriteX        <= '0;
            WriteY        <= '0;
            best_out      <= '0;
            tbest_out     <= '0;
            overrun       <= 1'b0;
            stray_err     <= 1'b0;
        end else begin
            state         <= state_next;
            old_frame_clk <= frame_clk;
            if (state == IDLE && frame_rise) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (push) begin
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 10'd1;
                end else begin
                    x_cnt <= x_cnt + 10'd1;
                end
            end
            WritePixel <= pop;
            if (pop) begin
                WriteX    <= fifo_dout.x;
                WriteY    <= fifo_dout.y;
                best_out  <= res_index;
                tbest_out <= res_t;
            end
            overrun <= frame_rise && (state != IDLE);
            if (res_valid && fifo_empty) stray_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ray_scheduler.sv
// tb/tb_ray_scheduler.sv - directed bench for ray_scheduler with a 4x2 frame
module tb_ray_scheduler;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int MO = 2;

    logic        Clk = 1'b0;
    logic        Reset_n, frame_clk, req_valid, req_ready;
    logic [9:0]  req_x, req_y, WriteX, WriteY;
    logic        res_valid, WritePixel, busy, frame_done, overrun, stray_err;
    logic [1:0]  res_index, best_out;
    logic [63:0] res_t, tbest_out;

    always #5 Clk = ~Clk;

    ray_scheduler #(.H_RES(H), .V_RES(V), .MAX_OUTSTANDING(MO)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .res_valid(res_valid), .res_index(res_index), .res_t(res_t),
        .WritePixel(WritePixel), .WriteX(WriteX), .WriteY(WriteY),
        .best_out(best_out), .tbest_out(tbest_out), .busy(busy),
        .frame_done(frame_done), .overrun(overrun), .stray_err(stray_err)
    );

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [1:0]  best;
        logic [63:0] tbest;
    } pix_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        int         due;
    } pend_t;

    typedef struct {
        int    lat;
        bit    stall;
        int    overrun_at;
        int    exp_overrun;
        string tag;
    } cfg_t;

    pend_t pipe[$];
    pix_t  wr_q[$];
    pix_t  exp_pix [8];
    cfg_t  cfgs [4];

    int n_tests = 0, n_fail = 0;
    int cyc = 0, lat = 3, n_acc = 0, n_sent = 0, n_done = 0, n_overrun = 0;
    int max_out = 0, stall_left = 0, done_wr_count = 0;
    bit stall_mode = 0, stall_started = 0, inject_stray = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pipeline model and output monitor, all on the falling edge.
    always @(negedge Clk) begin
        cyc++;
        if (WritePixel === 1'b1) wr_q.push_back('{WriteX, WriteY, best_out, tbest_out});
        if (frame_done === 1'b1) begin
            n_done++;
            done_wr_count = wr_q.size();
        end
        if (overrun === 1'b1) n_overrun++;
        res_valid = 1'b0;
        res_index = 2'd0;
        res_t     = 64'd0;
        if (Reset_n !== 1'b1) begin
            pipe.delete();
            req_ready = 1'b0;
        end else begin
            if (inject_stray) begin
                res_valid    = 1'b1;
                res_index    = 2'd3;
                res_t        = 64'hEFFF_FFFF_FFFF_FFFF;
                inject_stray = 0;
            end else if (pipe.size() > 0 && pipe[0].due <= cyc) begin
                res_valid = 1'b1;
                res_index = pipe[0].x[1:0];
                res_t     = 64'(pipe[0].y);
                void'(pipe.pop_front());
                n_sent++;
            end
            if (stall_mode && !stall_started && req_valid === 1'b1 && req_x == 10'd2 && req_y == 10'd0) begin
                stall_started = 1;
                stall_left    = 5;
            end
            if (stall_left > 0) begin
                req_ready = 1'b0;
                stall_left--;
                check("stall_hold", 64'({req_valid, req_x, req_y}), 64'({1'b1, 10'd2, 10'd0}));
            end else begin
                req_ready = 1'b1;
            end
            if (req_valid === 1'b1 && req_ready) begin
                pipe.push_back('{req_x, req_y, cyc + lat});
                n_acc++;
            end
            if (n_acc - n_sent > max_out) max_out = n_acc - n_sent;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic pulse_frame();
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, 64'({WritePixel, req_valid, busy, frame_done, overrun, stray_err}), 64'd0);
        check({tag, "_coords"}, 64'({req_x, req_y, WriteX, WriteY, best_out}), 64'd0);
        check({tag, "_tbest"}, tbest_out, 64'd0);
    endtask

    task automatic run_frame(input cfg_t c);
        int i;
        wr_q.delete();
        n_done = 0; n_overrun = 0; n_acc = 0; n_sent = 0; max_out = 0; done_wr_count = 0;
        lat = c.lat; stall_mode = c.stall; stall_started = 0; stall_left = 0;
        pulse_frame();
        if (c.overrun_at > 0) begin
            i = 0;
            while (n_acc < c.overrun_at && i < 500) begin tick(); i++; end
            check({c.tag, "_ovr_reach"}, 64'(n_acc >= c.overrun_at), 64'd1);
            pulse_frame();
        end
        i = 0;
        while (n_done == 0 && i < 2000) begin tick(); i++; end
        check({c.tag, "_done_seen"}, 64'(n_done > 0), 64'd1);
        repeat (20) @(posedge Clk);
        #2;
        check({c.tag, "_writes"}, 64'(wr_q.size()), 64'd8);
        for (int k = 0; k < 8 && k < wr_q.size(); k++) begin
            check($sformatf("%s_pix%0d", c.tag, k), 64'({wr_q[k].x, wr_q[k].y, wr_q[k].best}),
                  64'({exp_pix[k].x, exp_pix[k].y, exp_pix[k].best}));
            check($sformatf("%s_tbest%0d", c.tag, k), wr_q[k].tbest, exp_pix[k].tbest);
        end
        check({c.tag, "_n_done"}, 64'(n_done), 64'd1);
        check({c.tag, "_done_at_last"}, 64'(done_wr_count), 64'd8);
        check({c.tag, "_overrun"}, 64'(n_overrun), 64'(c.exp_overrun));
        check({c.tag, "_max_out"}, 64'(max_out), 64'(MO));
        check({c.tag, "_accepts"}, 64'(n_acc), 64'd8);
        check({c.tag, "_idle"}, 64'({busy, req_valid, stray_err}), 64'd0);
        check({c.tag, "_stalled"}, 64'(stall_started), 64'(c.stall));
    endtask

    initial begin
        int i;
        exp_pix[0] = '{10'd0, 10'd0, 2'd0, 64'd0};
        exp_pix[1] = '{10'd1, 10'd0, 2'd1, 64'd0};
        exp_pix[2] = '{10'd2, 10'd0, 2'd2, 64'd0};
        exp_pix[3] = '{10'd3, 10'd0, 2'd3, 64'd0};
        exp_pix[4] = '{10'd0, 10'd1, 2'd0, 64'd1};
        exp_pix[5] = '{10'd1, 10'd1, 2'd1, 64'd1};
        exp_pix[6] = '{10'd2, 10'd1, 2'd2, 64'd1};
        exp_pix[7] = '{10'd3, 10'd1, 2'd3, 64'd1};
        cfgs[0] = '{3,  0, 0, 0, "lat3"};
        cfgs[1] = '{10, 0, 0, 0, "lat10"};
        cfgs[2] = '{3,  1, 0, 0, "stall"};
        cfgs[3] = '{3,  0, 4, 1, "ovr"};

        Reset_n = 1'b0; frame_clk = 1'b0; req_ready = 1'b0;
        res_valid = 1'b0; res_index = 2'd0; res_t = 64'd0;
        repeat (2) @(posedge Clk);
        #2;
        check_all_zero("reset");
        Reset_n = 1'b1;
        tick();

        foreach (cfgs[k]) run_frame(cfgs[k]);

        // Result arriving with nothing in flight.
        wr_q.delete();
        inject_stray = 1;
        repeat (3) tick();
        check("stray_set", 64'(stray_err), 64'd1);
        check("stray_nowrite", 64'(wr_q.size()), 64'd0);
        check("stray_idle", 64'(busy), 64'd0);
        repeat (10) tick();
        check("stray_sticky", 64'(stray_err), 64'd1);

        // Reset in the middle of a frame.
        n_acc = 0; n_sent = 0; lat = 3; stall_mode = 0;
        frame_clk = 1'b1;
        i = 0;
        while (n_acc < 3 && i < 500) begin tick(); i++; end
        check("midrst_reach", 64'(n_acc >= 3), 64'd1);
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        tick();
        check_all_zero("midrst");
        Reset_n = 1'b1;
        repeat (3) tick();
        check("midrst_quiet", 64'({busy, stray_err, WritePixel}), 64'd0);
        cfgs[0].tag = "restart";
        run_frame(cfgs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
